swap_sequencer: RTL

- Multi-cycle swap controller in front of a 2^N x BITS register file with one internal read port and one internal write port.
- Arbitrates those ports between host reads, host writes and a swap engine.
- On request, the engine exchanges the contents of two addresses in four cycles: read A, read B, write A, write B.
- Provides the hand-shaked swap service for the register-file datapath, replacing single-cycle dual-write swapping.

---
 rtl/swap_sequencer_if.sv | 41 ++++
 rtl/swap_sequencer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/swap_sequencer_if.sv
// rtl/swap_sequencer_if.sv - handshake bundle between host and swap_sequencer
//
// Purpose: groups the swap request/response, host write and host read
//          channels of the swap sequencer into one bundle.
// Modports:
//    master - host side: drives requests, addresses and write data;
//             observes the ready/done/read-data returns.
//    slave  - sequencer side: the mirror image of master.
// Signals:
//    swap_req, A_addr, B_addr, swap_ready, swap_done  - swap channel
//    w_en, w_addr, w_data, w_ready                    - host write channel
//    r_en, r_addr, r_ready, r_data, r_valid           - host read channel
interface swap_sequencer_if #(
   parameter int N    = 3,
   parameter int BITS = 8
);
   logic            swap_req;
   logic [N-1:0]    A_addr;
   logic [N-1:0]    B_addr;
   logic            swap_ready;
   logic            swap_done;
   logic            w_en;
   logic [N-1:0]    w_addr;
   logic [BITS-1:0] w_data;
   logic            w_ready;
   logic            r_en;
   logic [N-1:0]    r_addr;
   logic            r_ready;
   logic [BITS-1:0] r_data;
   logic            r_valid;

   modport master (
      output swap_req, A_addr, B_addr, w_en, w_addr, w_data, r_en, r_addr,
      input  swap_ready, swap_done, w_ready, r_ready, r_data, r_valid
   );

   modport slave (
      input  swap_req, A_addr, B_addr, w_en, w_addr, w_data, r_en, r_addr,
      output swap_ready, swap_done, w_ready, r_ready, r_data, r_valid
   );
endinterface

// File: rtl/swap_sequencer.sv
// rtl/swap_sequencer.sv - four-cycle swap engine arbitrating a 2^N x BITS register file
//
// Purpose: owns a register file with one read port and one write port and
//          shares them between host reads, host writes and a swap engine that
//          exchanges two entries as read A, read B, write A, write B.
// Ports:
//    clk  - clock, all state updates on the rising edge
//    rst  - synchronous active-high reset; clears memory and aborts swaps
//    bus  - swap_sequencer_if.slave: swap, host write and host read channels
// Configuration macro:
//    SWAP_SAME_ADDR_BYPASS_EN - when defined, a swap with A_addr==B_addr is
//    accepted without leaving IDLE and its done pulse follows one cycle later.
module swap_sequencer #(
   parameter int N    = 3,
   parameter int BITS = 8
) (
   input  logic           clk,
   input  logic           rst,
   swap_sequencer_if.slave bus
);
   localparam int DEPTH = 1 << N;

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B} state_t;

   state_t          state_q, state_d;
   logic [BITS-1:0] mem_q [DEPTH];
   logic [N-1:0]    a_q, a_d, b_q, b_d;
   logic [BITS-1:0] tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
   // Read path is two registers deep: rd_buf captures the array at the
   // accepting edge (so it sees the pre-write value), r_data presents it
   // one edge later.
   logic [BITS-1:0] rd_buf_q, rd_buf_d;
   logic            rd_pend_q, rd_pend_d;
   logic [BITS-1:0] r_data_q;
   logic            r_valid_q;
   logic            swap_done_q, swap_done_d;
   logic            mem_we;
   logic [N-1:0]    mem_waddr;
   logic [BITS-1:0] mem_wdata;
   logic            swap_ready, w_ready, r_ready;
   logic            bypass_hit;

`ifdef SWAP_SAME_ADDR_BYPASS_EN
   logic            bypass_q, bypass_d;
   assign bypass_hit = (bus.A_addr == bus.B_addr);
`else
   assign bypass_hit = 1'b0;
`endif

   always_comb begin
      swap_ready  = !rst && (state_q == IDLE);
      w_ready     = !rst && (state_q == IDLE);
      // The read port is free whenever the engine is not reading.
      r_ready     = !rst && (state_q == IDLE || state_q == WR_A || state_q == WR_B);

      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      tmp_a_d     = tmp_a_q;
      tmp_b_d     = tmp_b_q;
      mem_we      = 1'b0;
      mem_waddr   = bus.w_addr;
      mem_wdata   = bus.w_data;
      swap_done_d = 1'b0;
      rd_pend_d   = bus.r_en && r_ready;
      rd_buf_d    = rd_pend_d ? mem_q[bus.r_addr] : rd_buf_q;
`ifdef SWAP_SAME_ADDR_BYPASS_EN
      bypass_d    = 1'b0;
      if (bypass_q) swap_done_d = 1'b1;
`endif

      case (state_q)
         IDLE: begin
            mem_we = bus.w_en;
            if (bus.swap_req) begin
               if (bypass_hit) begin
`ifdef SWAP_SAME_ADDR_BYPASS_EN
                  bypass_d = 1'b1;
`endif
               end else begin
                  a_d     = bus.A_addr;
                  b_d     = bus.B_addr;
                  state_d = RD_A;
               end
            end
         end
         RD_A: begin
            tmp_a_d = mem_q[a_q];
            state_d = RD_B;
         end
         RD_B: begin
            tmp_b_d = mem_q[b_q];
            state_d = WR_A;
         end
         WR_A: begin
            mem_we    = 1'b1;
            mem_waddr = a_q;
            mem_wdata = tmp_b_q;
            state_d   = WR_B;
         end
         WR_B: begin
            mem_we      = 1'b1;
            mem_waddr   = b_q;
            mem_wdata   = tmp_a_q;
            swap_done_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         tmp_a_q     <= '0;
         tmp_b_q     <= '0;
         rd_buf_q    <= '0;
         rd_pend_q   <= 1'b0;
         r_data_q    <= '0;
         r_valid_q   <= 1'b0;
         swap_done_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         tmp_a_q     <= tmp_a_d;
         tmp_b_q     <= tmp_b_d;
         rd_buf_q    <= rd_buf_d;
         rd_pend_q   <= rd_pend_d;
         r_valid_q   <= rd_pend_q;
         swap_done_q <= swap_done_d;
         if (rd_pend_q) r_data_q <= rd_buf_q;
         if (mem_we) mem_q[mem_waddr] <= mem_wdata;
      end
   end

`ifdef SWAP_SAME_ADDR_BYPASS_EN
   always_ff @(posedge clk) begin
      if (rst) bypass_q <= 1'b0;
      else     bypass_q <= bypass_d;
   end
`endif

   assign bus.swap_ready = swap_ready;
   assign bus.w_ready    = w_ready;
   assign bus.r_ready    = r_ready;
   assign bus.swap_done  = swap_done_q;
   assign bus.r_data     = r_data_q;
   assign bus.r_valid    = r_valid_q;
endmodule
